fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 32, meaning the byte size of the instruction memory (multiple of 4).
REQ-002 SHALL have parameter XLEN, default 32, meaning the width of the PC and instruction.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1, a pulse that begins fetching from PC 0.
REQ-006 SHALL have ports load_en, input, 1; load_addr, input, 5; load_data, input, 8: the boot-time byte write request.
REQ-007 SHALL have ports mem_we, output, 1; mem_waddr, output, 5; mem_wdata, output, 8: the memory byte write port.
REQ-008 SHALL have ports mem_pc, output, XLEN; mem_instr, input, XLEN: the memory read port, combinational, little-endian word at mem_pc.
REQ-009 SHALL have ports instr_valid, output, 1; instr_ready, input, 1; instr_data, output, XLEN; instr_pc, output, XLEN: the decode handshake.
REQ-010 SHALL have ports redirect_en, input, 1; redirect_pc, input, XLEN: the branch/jump redirect.
REQ-011 SHALL have ports busy, output, 1 (state is LOAD or FETCH) and halted, output, 1 (state is HALT).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, FETCH, HALT.
REQ-013 IDLE and HALT: load_en=1 SHALL go to LOAD; otherwise start=1 SHALL go to FETCH with pc=0; load_en has priority.
REQ-014 LOAD: each cycle with load_en=1 SHALL assert mem_we=1, mem_waddr=load_addr, mem_wdata=load_data in the same cycle (combinational pass-through); load_en=0 SHALL return to IDLE.
REQ-015 mem_we SHALL be 0 in every state other than LOAD; start SHALL be ignored in LOAD and FETCH.
REQ-016 mem_pc SHALL equal the internal pc register at all times.
REQ-017 FETCH: when (!instr_valid || instr_ready) and no redirect, SHALL register instr_data=mem_instr, instr_pc=pc, instr_valid=1, and set pc=pc+4; latency from pc to instr_valid is 1 cycle.
REQ-018 FETCH: instr_valid=1 && instr_ready=0 SHALL hold instr_data, instr_pc, and pc stable (stall).
REQ-019 FETCH: instr_valid=1 && instr_ready=1 with capture SHALL keep instr_valid=1 (back-to-back, one word per cycle).
REQ-020 End of memory: after capturing the word at pc=MEM_BYTES-4, SHALL go to HALT once that word is accepted (instr_ready=1), with instr_valid cleared in the same cycle; no wrap-around to 0.
REQ-021 Redirect in FETCH SHALL have priority over capture: it SHALL clear instr_valid next cycle and set pc={redirect_pc[XLEN-1:2],2'b00}.
REQ-022 Redirect with aligned target >= MEM_BYTES SHALL go to HALT with instr_valid=0.
REQ-023 redirect_en outside FETCH SHALL be ignored.
REQ-024 The arithmetic pc+4 SHALL be XLEN-bit; the bounds check SHALL use an unsigned comparison.

Reset
REQ-025 reset=0 SHALL asynchronously force state=IDLE, pc=0, instr_valid=0, instr_data=0, instr_pc=0.
REQ-026 During reset and in IDLE, outputs SHALL be mem_we=0, busy=0, halted=0.
REQ-027 Reset asserted mid-LOAD or mid-FETCH SHALL abort immediately; a partially loaded memory is not cleared.

Structure
REQ-028 A shared package SHALL hold the state enum, MEM_BYTES default, XLEN, and WORD_BYTES=4.
REQ-029 Sub-module pc_gen SHALL own pc: reset, start-clear, increment, redirect-align, and the end-of-memory flag.

Verification
REQ-030 Load bytes 33,03,94,30 at addresses 0..3, then start, ready=1 -> next cycle instr_valid=1, instr_data=0x30940333, instr_pc=0.
REQ-031 Full 32-byte image, ready=1 -> 8 consecutive valid words, pc 0..28, then halted=1, instr_valid=0.
REQ-032 ready held 0 for 3 cycles at pc=8 -> instr_data/instr_pc constant, mem_pc=12 constant.
REQ-033 redirect_pc=0x0000000E during a stall -> next instr_pc=0x0C, no word from the old stream delivered.
REQ-034 redirect_pc=0x40 -> halted=1, instr_valid=0; start then restarts at pc=0.
REQ-035 reset=0 asynchronously mid-FETCH -> instr_valid=0 and mem_pc=0 before the next clk edge; load_en and start asserted together in IDLE -> LOAD.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding and the default memory/word geometry.
package fetch_ctrl_pkg;

  localparam int DEF_XLEN      = 32;
  localparam int DEF_MEM_BYTES = 32;
  localparam int WORD_BYTES    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_ctrl_pc_gen.sv
// Program counter owner: clears on start, steps one word per capture,
// takes word-aligned redirect targets and flags the end of memory.
module fetch_ctrl_pc_gen
  import fetch_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int XLEN      = DEF_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            adv,
  input  logic            redir,
  input  logic [XLEN-1:0] redir_pc,
  output logic [XLEN-1:0] pc,
  output logic            at_end,
  output logic            redir_oob
);

  localparam logic [XLEN-1:0] END_ADDR   = XLEN'(MEM_BYTES);
  localparam logic [XLEN-1:0] STEP       = XLEN'(WORD_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(WORD_BYTES - 1);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] target;

  // Redirect targets drop the byte offset; both bounds checks are unsigned.
  assign target    = redir_pc & ALIGN_MASK;
  assign redir_oob = (target >= END_ADDR);
  assign at_end    = (pc_q >= END_ADDR);
  assign pc        = pc_q;

  // Next pc: start wins, then redirect, then sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (clr) begin
      pc_d = '0;
    end else if (redir) begin
      pc_d = target;
    end else if (adv) begin
      pc_d = pc_q + STEP;
    end
  end

  // pc register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: boot-time byte loader into an external
// memory, then a single-entry fetch buffer feeding decode with a
// valid/ready handshake, branch redirect and end-of-memory halt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int XLEN      = DEF_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            load_en,
  input  logic [4:0]      load_addr,
  input  logic [7:0]      load_data,
  output logic            mem_we,
  output logic [4:0]      mem_waddr,
  output logic [7:0]      mem_wdata,
  output logic [XLEN-1:0] mem_pc,
  input  logic [XLEN-1:0] mem_instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic            halted
);

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] ipc_q, ipc_d;

  logic            pc_clr, pc_adv, pc_redir;
  logic [XLEN-1:0] pc;
  logic            at_end, redir_oob;

  fetch_ctrl_pc_gen #(
    .MEM_BYTES (MEM_BYTES),
    .XLEN      (XLEN)
  ) u_pc_gen (
    .clk       (clk),
    .reset     (reset),
    .clr       (pc_clr),
    .adv       (pc_adv),
    .redir     (pc_redir),
    .redir_pc  (redirect_pc),
    .pc        (pc),
    .at_end    (at_end),
    .redir_oob (redir_oob)
  );

  assign mem_pc      = pc;
  assign mem_waddr   = load_addr;
  assign mem_wdata   = load_data;
  assign instr_valid = valid_q;
  assign instr_data  = data_q;
  assign instr_pc    = ipc_q;
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_FETCH);
  assign halted      = (state_q == ST_HALT);

  // Next state, fetch buffer update, pc controls and memory write strobe.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    data_d   = data_q;
    ipc_d    = ipc_q;
    pc_clr   = 1'b0;
    pc_adv   = 1'b0;
    pc_redir = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (load_en) begin
          state_d = ST_LOAD;
        end else if (start) begin
          state_d = ST_FETCH;
          pc_clr  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_en) begin
          mem_we = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (redirect_en) begin
          // Redirect flushes the buffered word, even one being accepted.
          valid_d  = 1'b0;
          pc_redir = 1'b1;
          if (redir_oob) begin
            state_d = ST_HALT;
          end
        end else if (!valid_q || instr_ready) begin
          if (at_end) begin
            // Last word has just been taken (or nothing is left to fetch).
            valid_d = 1'b0;
            state_d = ST_HALT;
          end else begin
            valid_d = 1'b1;
            data_d  = mem_instr;
            ipc_d   = pc;
            pc_adv  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and fetch buffer registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
    end
  end

endmodule
